// File: rtl/regfile_if.sv
// regfile_if: operand-side bus of regfile_mp; master drives write/reserve/read indices, slave returns read data, busy bits and wr_err
interface regfile_if #(
    parameter int WIDTH = 16,
    parameter int NREGS = 8,
    parameter int AW    = 3
);
    logic [WIDTH-1:0] data_in;
    logic [AW-1:0]    writenum;
    logic             write;
    logic [AW-1:0]    readnum_a;
    logic [AW-1:0]    readnum_b;
    logic [WIDTH-1:0] data_out_a;
    logic [WIDTH-1:0] data_out_b;
    logic             reserve;
    logic [AW-1:0]    reservenum;
    logic             busy_a;
    logic             busy_b;
    logic [NREGS-1:0] busy_mask;
    logic             wr_err;
    modport master (
        output data_in, writenum, write, readnum_a, readnum_b, reserve, reservenum,
        input  data_out_a, data_out_b, busy_a, busy_b, busy_mask, wr_err
    );
    modport slave (
        input  data_in, writenum, write, readnum_a, readnum_b, reserve, reservenum,
        output data_out_a, data_out_b, busy_a, busy_b, busy_mask, wr_err
    );
endinterface

// File: rtl/regfile_mp.sv
// regfile_mp: NREGS x WIDTH register file, one sync write port, two comb read ports, busy scoreboard, wr_err pulse
// clk/reset: rising-edge clock, sync active-high reset; bus: regfile_if.slave (write, reserve, read A/B, busy, wr_err)
module regfile_mp #(
    parameter int WIDTH  = 16,
    parameter int NREGS  = 8,
    parameter int AW     = 3,
    parameter int BYPASS = 1
) (
    input logic       clk,
    input logic       reset,
    regfile_if.slave  bus
);
    localparam logic [AW:0] N = (AW+1)'(NREGS);
    logic [WIDTH-1:0] regs [NREGS];
    logic [NREGS-1:0] busy;
    logic             err_q;
    logic             wr_ok, rs_ok, rs_busy, err_d, byp_a, byp_b, bz_a, bz_b;
    logic [WIDTH-1:0] rd_a, rd_b;
    assign wr_ok = bus.write && ({1'b0, bus.writenum} < N);
    assign rs_ok = bus.reserve && ({1'b0, bus.reservenum} < N);
    always_comb begin
        rs_busy = 1'b0;
        rd_a    = '0;
        rd_b    = '0;
        bz_a    = 1'b0;
        bz_b    = 1'b0;
        for (int i = 0; i < NREGS; i++) begin
            if (bus.reservenum == AW'(i)) rs_busy = busy[i];
            if (bus.readnum_a == AW'(i)) begin
                rd_a = regs[i];
                bz_a = busy[i];
            end
            if (bus.readnum_b == AW'(i)) begin
                rd_b = regs[i];
                bz_b = busy[i];
            end
        end
    end
    // a reserve on a busy register is only legal when the same edge's write retires the old producer
    assign err_d = (bus.write && !wr_ok) || (bus.reserve && !rs_ok) ||
                   (rs_ok && rs_busy && !(wr_ok && bus.writenum == bus.reservenum));
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
            busy  <= '0;
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
            for (int i = 0; i < NREGS; i++) begin
                if (wr_ok && bus.writenum == AW'(i)) begin
                    regs[i] <= bus.data_in;
                    busy[i] <= 1'b0;
                end
                if (rs_ok && bus.reservenum == AW'(i)) busy[i] <= 1'b1;
            end
        end
    end
    assign byp_a = (BYPASS != 0) && wr_ok && (bus.writenum == bus.readnum_a);
    assign byp_b = (BYPASS != 0) && wr_ok && (bus.writenum == bus.readnum_b);
    assign bus.data_out_a = byp_a ? bus.data_in : rd_a;
    assign bus.data_out_b = byp_b ? bus.data_in : rd_b;
    assign bus.busy_a     = byp_a ? (rs_ok && bus.reservenum == bus.readnum_a) : bz_a;
    assign bus.busy_b     = byp_b ? (rs_ok && bus.reservenum == bus.readnum_b) : bz_b;
    assign bus.busy_mask  = busy;
    assign bus.wr_err     = err_q;
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: scoreboard bench driving an 8-reg bypass build and a 6-reg no-bypass build against a spec-level model
module tb_regfile_mp;
    typedef struct packed {
        logic [15:0] da;
        logic [15:0] db;
        logic        ba;
        logic        bb;
        logic [7:0]  mask;
        logic        err;
    } exp_t;
    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] din;
    logic [2:0]  wn, ra, rb, rn;
    logic        wr, rs;
    int          checks = 0;
    int          errors = 0;
    exp_t        q0[$], q1[$];
    logic [15:0] m_reg [2][8];
    logic        m_busy [2][8];
    logic        m_err [2];
    int          nr [2] = '{8, 6};
    int          by [2] = '{1, 0};
    regfile_if #(.WIDTH(16), .NREGS(8), .AW(3)) if0 ();
    regfile_if #(.WIDTH(16), .NREGS(6), .AW(3)) if1 ();
    assign if0.data_in = din;  assign if0.writenum = wn;  assign if0.write = wr;
    assign if0.readnum_a = ra; assign if0.readnum_b = rb;
    assign if0.reserve = rs;   assign if0.reservenum = rn;
    assign if1.data_in = din;  assign if1.writenum = wn;  assign if1.write = wr;
    assign if1.readnum_a = ra; assign if1.readnum_b = rb;
    assign if1.reserve = rs;   assign if1.reservenum = rn;
    regfile_mp #(.WIDTH(16), .NREGS(8), .AW(3), .BYPASS(1)) dut0 (.clk(clk), .reset(reset), .bus(if0));
    regfile_mp #(.WIDTH(16), .NREGS(6), .AW(3), .BYPASS(0)) dut1 (.clk(clk), .reset(reset), .bus(if1));
    always #5 clk = ~clk;

    function automatic void read_port(input int k, input logic [2:0] idx, output logic [15:0] d, output logic b);
        d = 16'h0;
        b = 1'b0;
        if (idx < nr[k]) begin
            d = m_reg[k][idx];
            b = m_busy[k][idx];
            if (by[k] == 1 && wr && wn == idx) begin
                d = din;
                b = rs && rn == idx;
            end
        end
    endfunction

    function automatic exp_t expect_of(input int k);
        exp_t e;
        read_port(k, ra, e.da, e.ba);
        read_port(k, rb, e.db, e.bb);
        e.mask = 8'h0;
        for (int i = 0; i < nr[k]; i++) e.mask[i] = m_busy[k][i];
        e.err = m_err[k];
        return e;
    endfunction

    function automatic void update(input int k);
        logic e;
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                m_reg[k][i]  = 16'h0;
                m_busy[k][i] = 1'b0;
            end
            m_err[k] = 1'b0;
        end else begin
            e = (wr && wn >= nr[k]) || (rs && rn >= nr[k]) ||
                (rs && rn < nr[k] && m_busy[k][rn] && !(wr && wn == rn));
            if (wr && wn < nr[k]) begin
                m_reg[k][wn]  = din;
                m_busy[k][wn] = 1'b0;
            end
            if (rs && rn < nr[k]) m_busy[k][rn] = 1'b1;
            m_err[k] = e;
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    task automatic step(input logic r, input logic w, input logic [2:0] w_n, input logic [15:0] d,
                        input logic [2:0] r_a, input logic [2:0] r_b, input logic s, input logic [2:0] s_n);
        reset = r; wr = w; wn = w_n; din = d; ra = r_a; rb = r_b; rs = s; rn = s_n;
        q0.push_back(expect_of(0));
        q1.push_back(expect_of(1));
        @(posedge clk);
        update(0);
        update(1);
        #1;
    endtask

    initial begin
        exp_t e0, e1;
        forever begin
            @(negedge clk);
            if (q0.size() > 0 && q1.size() > 0) begin
                e0 = q0.pop_front();
                e1 = q1.pop_front();
                chk("d0_data_a", 32'(if0.data_out_a), 32'(e0.da));
                chk("d0_data_b", 32'(if0.data_out_b), 32'(e0.db));
                chk("d0_busy_a", 32'(if0.busy_a), 32'(e0.ba));
                chk("d0_busy_b", 32'(if0.busy_b), 32'(e0.bb));
                chk("d0_mask", 32'(if0.busy_mask), 32'(e0.mask));
                chk("d0_wr_err", 32'(if0.wr_err), 32'(e0.err));
                chk("d1_data_a", 32'(if1.data_out_a), 32'(e1.da));
                chk("d1_data_b", 32'(if1.data_out_b), 32'(e1.db));
                chk("d1_busy_a", 32'(if1.busy_a), 32'(e1.ba));
                chk("d1_busy_b", 32'(if1.busy_b), 32'(e1.bb));
                chk("d1_mask", 32'({2'b00, if1.busy_mask}), 32'(e1.mask));
                chk("d1_wr_err", 32'(if1.wr_err), 32'(e1.err));
            end
        end
    end

    initial begin
        reset = 1'b1; wr = 1'b0; wn = 3'd0; din = 16'h0; ra = 3'd0; rb = 3'd0; rs = 1'b0; rn = 3'd0;
        @(posedge clk);
        update(0);
        update(1);
        #1;
        step(0, 0, 0, 16'h0,    0, 1, 0, 0);
        step(0, 1, 0, 16'd5,    0, 1, 0, 0);
        step(0, 1, 1, 16'd6,    0, 1, 0, 0);
        step(0, 1, 2, 16'd7,    0, 1, 0, 0);
        step(0, 0, 0, 16'h0,    0, 1, 0, 0);
        step(0, 0, 0, 16'h0,    2, 2, 0, 0);
        step(0, 0, 3, 16'd15,   3, 3, 0, 0);
        step(0, 0, 0, 16'h0,    3, 3, 0, 0);
        step(0, 1, 4, 16'h00AA, 4, 0, 0, 0);
        step(0, 0, 0, 16'h0,    4, 4, 0, 0);
        step(0, 0, 0, 16'h0,    0, 5, 1, 5);
        step(0, 0, 0, 16'h0,    0, 5, 1, 5);
        step(0, 0, 0, 16'h0,    5, 5, 0, 0);
        step(0, 1, 5, 16'h1234, 5, 5, 0, 0);
        step(0, 0, 0, 16'h0,    5, 5, 0, 0);
        step(0, 1, 7, 16'h7777, 7, 6, 0, 0);
        step(0, 0, 0, 16'h0,    7, 6, 1, 6);
        step(0, 0, 0, 16'h0,    7, 6, 0, 0);
        step(0, 1, 2, 16'hBEEF, 2, 2, 1, 2);
        step(0, 0, 0, 16'h0,    2, 2, 0, 0);
        step(0, 1, 1, 16'h9999, 1, 2, 1, 3);
        step(0, 0, 0, 16'h0,    1, 2, 0, 0);
        for (int n = 0; n < 600; n++)
            step($urandom_range(0, 63) == 0, $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)),
                 16'($urandom), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                 $urandom_range(0, 3) == 0, 3'($urandom_range(0, 7)));
        @(negedge clk);
        @(negedge clk);
        chk("drain", 32'(q0.size() + q1.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
